// File: rtl/cs_pkg.sv
// Shared definitions for the windowed-average (CS) datapath and its output stage.
package cs_pkg;

    localparam int SAMPLE_W = 8;
    localparam int AVG_W    = 10;
    localparam int WINDOW   = 9;

    typedef logic [AVG_W-1:0] avg_t;

    // Ceiling log2 for elaboration-time sizing; returns 0 for v <= 1.
    function automatic int cs_log2(input int v);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cs_sync_fifo.sv
// First-word-fall-through synchronous FIFO; occupancy is tracked explicitly so
// full/empty never rely on pointer equality.
module cs_sync_fifo
    import cs_pkg::*;
#(
    parameter int DW    = AVG_W,
    parameter int DEPTH = 8,
    parameter int LVL_W = cs_log2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DW-1:0]    din,
    output logic [DW-1:0]    dout,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int AW = cs_log2(DEPTH);

    logic [DW-1:0]    mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Status decode and guarded push/pop qualification.
    always_comb begin
        full_s    = (level_r == LVL_W'(DEPTH));
        empty_s   = (level_r == {LVL_W{1'b0}});
        push_ok_s = push & (~full_s | pop);
        pop_ok_s  = pop & ~empty_s;
    end

    // Storage, pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign level = level_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/cs_avg_out_buffer.sv
// Output stage of the CS averager: discards warm-up results, buffers valid ones
// and exposes them over valid/ready with sticky overflow and drop accounting.
module cs_avg_out_buffer
    import cs_pkg::*;
#(
    parameter int AVG_W  = cs_pkg::AVG_W,
    parameter int WARMUP = WINDOW,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8,
    parameter int LVL_W  = cs_log2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AVG_W-1:0]  Y,
    input  logic              y_en,
    output logic [AVG_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  level,
    output logic              warm,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt,
    input  logic              clr_ovf
);

    localparam int CNT_W = cs_log2(WARMUP + 1);

    logic [CNT_W-1:0]  warm_cnt_r;
    logic              warm_r;
    logic              overflow_r;
    logic [DROP_W-1:0] drop_cnt_r;
    logic              push_req_s;
    logic              pop_s;
    logic              drop_s;
    logic              fifo_push_s;
    logic              full_s;
    logic              empty_s;

    // A drop only happens when full and the head is not leaving this cycle.
    always_comb begin
        push_req_s  = y_en & warm_r;
        pop_s       = ~empty_s & out_ready;
        drop_s      = push_req_s & full_s & ~pop_s;
        fifo_push_s = push_req_s & ~drop_s;
    end

    cs_sync_fifo #(
        .DW    (AVG_W),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push_s),
        .pop   (pop_s),
        .din   (Y),
        .dout  (out_data),
        .level (level),
        .full  (full_s),
        .empty (empty_s)
    );

    // Warm-up counter: the first WARMUP strobes after reset are discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt_r <= {CNT_W{1'b0}};
            warm_r     <= 1'b0;
        end else if (y_en && !warm_r) begin
            warm_cnt_r <= warm_cnt_r + CNT_W'(1);
            if (warm_cnt_r == CNT_W'(WARMUP - 1)) begin
                warm_r <= 1'b1;
            end
        end
    end

    // Sticky overflow and saturating drop counter; a same-cycle drop beats clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_W{1'b0}};
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (clr_ovf) begin
                drop_cnt_r <= DROP_W'(1);
            end else if (drop_cnt_r != {DROP_W{1'b1}}) begin
                drop_cnt_r <= drop_cnt_r + DROP_W'(1);
            end
        end else if (clr_ovf) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_W{1'b0}};
        end
    end

    assign out_valid = ~empty_s;
    assign warm      = warm_r;
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_cs_avg_out_buffer.sv
// Directed bench for cs_avg_out_buffer: warm-up, fill/drop, full push+pop,
// saturation/clear, mid-operation reset and a randomised-ready ramp.
module tb_cs_avg_out_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] Y;
    logic       y_en;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] level;
    logic       warm;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       clr_ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cs_avg_out_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .Y         (Y),
        .y_en      (y_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .warm      (warm),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clr_ovf   (clr_ovf)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic e, input int y, input logic r, input logic c);
        y_en      = e;
        Y         = 10'(y);
        out_ready = r;
        clr_ovf   = c;
        @(posedge clk);
        #1;
    endtask

    int q[$];
    int model_drops;
    logic rdy;
    logic mpop;

    initial begin
        reset = 1'b1; y_en = 1'b0; Y = 10'd0; out_ready = 1'b0; clr_ovf = 1'b0;
        tick(1'b0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_warm", warm, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        reset = 1'b0;

        // Warm-up: strobes 1..9 discarded, 10..12 pass through one cycle after capture
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1, i, 1'b1, 1'b0);
            chk("wu_warm", warm, (i >= 9) ? 1 : 0);
            chk("wu_valid", out_valid, (i >= 10) ? 1 : 0);
            if (i >= 10) chk("wu_data", out_data, i);
        end
        tick(1'b0, 0, 1'b1, 1'b0);
        chk("wu_empty", out_valid, 0);

        // Fill with 11 values while blocked: 3 dropped
        for (int i = 0; i < 11; i++) tick(1'b1, 100 + i, 1'b0, 1'b0);
        chk("fill_level", level, 8);
        chk("fill_head", out_data, 100);
        chk("fill_ovf", overflow, 1);
        chk("fill_drop", drop_cnt, 3);
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, 100 + i);
            tick(1'b0, 0, 1'b1, 1'b0);
        end
        chk("drain_empty", out_valid, 0);
        chk("drain_drop_kept", drop_cnt, 3);
        tick(1'b0, 0, 1'b0, 1'b1);
        chk("clr1_ovf", overflow, 0);
        chk("clr1_drop", drop_cnt, 0);

        // Full with simultaneous push and pop: no drop
        for (int i = 0; i < 8; i++) tick(1'b1, 200 + i, 1'b0, 1'b0);
        chk("full_level", level, 8);
        tick(1'b1, 300, 1'b1, 1'b0);
        chk("pp_level", level, 8);
        chk("pp_ovf", overflow, 0);
        chk("pp_drop", drop_cnt, 0);
        for (int i = 1; i <= 8; i++) begin
            chk("pp_data", out_data, (i == 8) ? 300 : 200 + i);
            tick(1'b0, 0, 1'b1, 1'b0);
        end
        chk("pp_empty", out_valid, 0);

        // Saturation of drop counter, then clear with and without a concurrent drop
        for (int i = 0; i < 8; i++) tick(1'b1, i, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) tick(1'b1, 999, 1'b0, 1'b0);
        chk("sat_drop", drop_cnt, 255);
        chk("sat_ovf", overflow, 1);
        tick(1'b0, 0, 1'b0, 1'b1);
        chk("clr2_ovf", overflow, 0);
        chk("clr2_drop", drop_cnt, 0);
        tick(1'b1, 999, 1'b0, 1'b1);
        chk("clrdrop_ovf", overflow, 1);
        chk("clrdrop_drop", drop_cnt, 1);
        chk("clrdrop_head", out_data, 0);
        for (int i = 0; i < 8; i++) tick(1'b0, 0, 1'b1, 1'b0);
        chk("sat_empty", out_valid, 0);

        // Reset in the middle of a push+pop with 5 entries buffered
        for (int i = 0; i < 5; i++) tick(1'b1, 500 + i, 1'b0, 1'b0);
        chk("mid_level", level, 5);
        reset = 1'b1;
        tick(1'b1, 555, 1'b1, 1'b0);
        reset = 1'b0;
        chk("mid_level0", level, 0);
        chk("mid_valid", out_valid, 0);
        chk("mid_data", out_data, 0);
        chk("mid_warm", warm, 0);
        chk("mid_ovf", overflow, 0);
        chk("mid_drop", drop_cnt, 0);
        for (int i = 1; i <= 9; i++) begin
            tick(1'b1, 600 + i, 1'b1, 1'b0);
            chk("rewu_valid", out_valid, 0);
        end
        chk("rewu_warm", warm, 1);
        tick(1'b1, 700, 1'b1, 1'b0);
        chk("rewu_data", out_data, 700);
        tick(1'b0, 0, 1'b1, 1'b1);
        chk("rewu_empty", out_valid, 0);

        // Ramp with random ready: output is the input stream minus reported drops
        model_drops = 0;
        for (int i = 0; i < 40; i++) begin
            rdy = 1'($urandom_range(0, 1));
            chk("ramp_valid", out_valid, (q.size() != 0) ? 1 : 0);
            if (q.size() != 0) chk("ramp_data", out_data, q[0]);
            mpop = (q.size() != 0) && rdy;
            if (mpop) void'(q.pop_front());
            if (q.size() < 8) q.push_back(i);
            else model_drops++;
            tick(1'b1, i, rdy, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            chk("rdrain_valid", out_valid, (q.size() != 0) ? 1 : 0);
            if (q.size() != 0) begin
                chk("rdrain_data", out_data, q[0]);
                void'(q.pop_front());
            end
            tick(1'b0, 0, 1'b1, 1'b0);
        end
        chk("ramp_drops", drop_cnt, model_drops);
        chk("ramp_ovf", overflow, (model_drops != 0) ? 1 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
